// File: rtl/sram_arbiter_if.sv
// Bus bundle between the two SRAM requesters (CPU, debug loader), the
// arbiter and the external 16-bit SRAM pins.
interface sram_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_done;

  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_done;

  logic [1:0]    gnt;
  logic [AW-1:0] ADDR;
  logic [DW-1:0] Data_to_SRAM;
  logic [DW-1:0] Data_from_SRAM;
  logic          OE;
  logic          WE;

  // Environment side: requesters drive requests, the SRAM drives read data.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output Data_from_SRAM,
    input  cpu_rdata, cpu_done, dbg_rdata, dbg_done,
    input  gnt, ADDR, Data_to_SRAM, OE, WE
  );

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  Data_from_SRAM,
    output cpu_rdata, cpu_done, dbg_rdata, dbg_done,
    output gnt, ADDR, Data_to_SRAM, OE, WE
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter and fixed-length access sequencer for the external
// SRAM. Every output is a register; the combinational block only computes
// next-state values.
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int AW            = 16,
  parameter int DW            = 16
) (
  input logic           Clk,
  input logic           Reset,
  sram_arbiter_if.slave bus
);
  localparam int CW = $clog2(ACCESS_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          last_dbg, last_dbg_nxt;    // 1: DBG owned the last access
  logic          armed_cpu, armed_cpu_nxt;
  logic          armed_dbg, armed_dbg_nxt;
  logic          is_write, is_write_nxt;
  logic [1:0]    gnt, gnt_nxt;
  logic [AW-1:0] addr, addr_nxt;
  logic [DW-1:0] wdata, wdata_nxt;
  logic          oe, oe_nxt;
  logic          we, we_nxt;
  logic          cpu_done, cpu_done_nxt;
  logic          dbg_done, dbg_done_nxt;
  logic [DW-1:0] cpu_rdata, cpu_rdata_nxt;
  logic [DW-1:0] dbg_rdata, dbg_rdata_nxt;
  logic          elig_cpu, elig_dbg, pick_dbg;

  assign elig_cpu = bus.cpu_req & armed_cpu;
  assign elig_dbg = bus.dbg_req & armed_dbg;

  // Register all state and outputs; reset drops any access in flight.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      last_dbg  <= 1'b1;
      armed_cpu <= 1'b1;
      armed_dbg <= 1'b1;
      is_write  <= 1'b0;
      gnt       <= 2'b00;
      addr      <= '0;
      wdata     <= '0;
      oe        <= 1'b1;
      we        <= 1'b1;
      cpu_done  <= 1'b0;
      dbg_done  <= 1'b0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      last_dbg  <= last_dbg_nxt;
      armed_cpu <= armed_cpu_nxt;
      armed_dbg <= armed_dbg_nxt;
      is_write  <= is_write_nxt;
      gnt       <= gnt_nxt;
      addr      <= addr_nxt;
      wdata     <= wdata_nxt;
      oe        <= oe_nxt;
      we        <= we_nxt;
      cpu_done  <= cpu_done_nxt;
      dbg_done  <= dbg_done_nxt;
      cpu_rdata <= cpu_rdata_nxt;
      dbg_rdata <= dbg_rdata_nxt;
    end
  end

  // Arbitration, access sequencing and next values of the registered pins.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    last_dbg_nxt  = last_dbg;
    is_write_nxt  = is_write;
    gnt_nxt       = gnt;
    addr_nxt      = addr;
    wdata_nxt     = wdata;
    oe_nxt        = oe;
    we_nxt        = we;
    cpu_done_nxt  = 1'b0;
    dbg_done_nxt  = 1'b0;
    cpu_rdata_nxt = cpu_rdata;
    dbg_rdata_nxt = dbg_rdata;
    pick_dbg      = 1'b0;
    // A dropped request re-arms its port on any cycle.
    armed_cpu_nxt = armed_cpu | ~bus.cpu_req;
    armed_dbg_nxt = armed_dbg | ~bus.dbg_req;

    case (state)
      IDLE: begin
        oe_nxt  = 1'b1;
        we_nxt  = 1'b1;
        gnt_nxt = 2'b00;
        if (elig_cpu || elig_dbg) begin
          // On a tie the port that did not own the last access wins.
          pick_dbg     = elig_dbg && (!elig_cpu || !last_dbg);
          gnt_nxt      = pick_dbg ? 2'b10 : 2'b01;
          addr_nxt     = pick_dbg ? bus.dbg_addr : bus.cpu_addr;
          wdata_nxt    = pick_dbg ? bus.dbg_wdata : bus.cpu_wdata;
          is_write_nxt = pick_dbg ? bus.dbg_we : bus.cpu_we;
          oe_nxt       = is_write_nxt;
          we_nxt       = ~is_write_nxt;
          cnt_nxt      = CNT_LOAD;
          last_dbg_nxt = pick_dbg;
          state_nxt    = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          oe_nxt    = 1'b1;
          we_nxt    = 1'b1;
          state_nxt = DONE;
          if (gnt[1]) begin
            dbg_done_nxt = 1'b1;
            if (!is_write) dbg_rdata_nxt = bus.Data_from_SRAM;
          end else begin
            cpu_done_nxt = 1'b1;
            if (!is_write) cpu_rdata_nxt = bus.Data_from_SRAM;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      DONE: begin
        // The owner must drop its request before it can be served again.
        if (gnt[1]) armed_dbg_nxt = ~bus.dbg_req;
        else        armed_cpu_nxt = ~bus.cpu_req;
        gnt_nxt   = 2'b00;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.gnt          = gnt;
  assign bus.ADDR         = addr;
  assign bus.Data_to_SRAM = wdata;
  assign bus.OE           = oe;
  assign bus.WE           = we;
  assign bus.cpu_done     = cpu_done;
  assign bus.dbg_done     = dbg_done;
  assign bus.cpu_rdata    = cpu_rdata;
  assign bus.dbg_rdata    = dbg_rdata;
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Two-port arbiter and access sequencer for the single external 16-bit SRAM. Requester 0 is the CPU memory path (MAR/MDR side). Requester 1 is the debug/program-loader port. The block grants one requester at a time using round-robin, drives ADDR, Data_to_SRAM, OE and WE for a fixed-length access, and returns read data with a one-cycle done pulse. It sits between the CPU memory interface and the SRAM pins.

Parameters:
ACCESS_CYCLES, 2, number of cycles address/data/strobes are held active per access (must be >= 1)
AW, 16, address width
DW, 16, data width

Ports:
Clk  in  1  clock
Reset  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU access request, level, held until cpu_done
cpu_we  in  1  1 = write, 0 = read; sampled at grant
cpu_addr  in  AW  CPU address; sampled at grant
cpu_wdata  in  DW  CPU write data; sampled at grant
cpu_rdata  out  DW  CPU read data; valid with cpu_done, held until the next CPU read completes
cpu_done  out  1  one-cycle completion pulse for CPU
dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rdata, dbg_done  same as cpu_* for the debug port
gnt  out  2  one-hot current owner: bit0 CPU, bit1 DBG; 00 when idle
ADDR  out  AW  SRAM address, registered
Data_to_SRAM  out  DW  SRAM write data, registered
Data_from_SRAM  in  DW  SRAM read data
OE  out  1  SRAM output enable, active-low
WE  out  1  SRAM write enable, active-low

Behaviour:
- Reset (async, active-high) takes effect immediately, including mid-access. State goes to IDLE. OE=1, WE=1, gnt=00, cpu_done=dbg_done=0, cpu_rdata=dbg_rdata=0, ADDR=0, Data_to_SRAM=0, last_owner=DBG (so CPU wins the first tie), armed_cpu=armed_dbg=1. An interrupted access is dropped; no done is issued.
- All outputs are registered. No combinational path runs from any input to any output.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - A requester is eligible when req=1 and its armed flag is 1.
  - Exactly one eligible requester: grant it.
  - Both eligible: grant the one that is not last_owner.
  - On grant: latch we/addr/wdata into ADDR/Data_to_SRAM, set gnt, load cnt=ACCESS_CYCLES-1, set last_owner, go to ACCESS.
  - In IDLE, ADDR and Data_to_SRAM hold their previous values; OE=WE=1.
- ACCESS:
  - Read: OE=0, WE=1. Write: WE=0, OE=1.
  - ADDR and Data_to_SRAM stay stable for all ACCESS_CYCLES cycles.
  - cnt decrements each cycle.
  - At the edge where cnt==0: for a read, capture Data_from_SRAM into the owner's rdata. Then go to DONE.
- DONE (exactly one cycle):
  - OE=WE=1, gnt still shows the owner, owner's done=1.
  - ADDR and Data_to_SRAM remain stable.
  - The owner's armed flag is cleared; the arbiter goes to IDLE.
- Armed rule: armed_x is set on any cycle where req_x==0. A requester must drop req for at least one cycle before its next access is granted. This prevents double service of a held request. The other requester is unaffected, so a pending request from the other port is granted in the IDLE cycle right after DONE.
- Latency: request eligible in IDLE at edge k gives ACCESS for cycles k+1 .. k+ACCESS_CYCLES, then done high in cycle k+ACCESS_CYCLES+1. The minimum period between grants is ACCESS_CYCLES+2 cycles.
- Requests that arrive during ACCESS or DONE are only evaluated in IDLE; nothing is queued beyond the req level.
- A req that drops mid-access does not abort the access; done is still issued.
- Widths: no arithmetic beyond cnt, which is $clog2(ACCESS_CYCLES+1) bits and never wraps because it is reloaded at grant.

Test Plan:
- Reset then CPU read addr 0x0010, SRAM model returns 0x1234, ACCESS_CYCLES=2 → OE low for exactly 2 cycles with ADDR=0x0010; cpu_done pulses 1 cycle, 3 cycles after the request edge; cpu_rdata=0x1234; WE stays 1.
- DBG write addr 0x00FF data 0xBEEF → WE low for 2 cycles; ADDR=0x00FF and Data_to_SRAM=0xBEEF stable through DONE; OE stays 1; dbg_done pulses once; dbg_rdata unchanged.
- cpu_req and dbg_req both rise in the same cycle right after reset → CPU is granted first (gnt=01). DBG is granted in the IDLE cycle after cpu_done (gnt=10). With both held and re-armed, the grants alternate CPU, DBG, CPU.
- CPU holds req high for 10 cycles after cpu_done without dropping it → no second CPU grant and gnt stays 00. Dropping req for 1 cycle and raising it again produces a new grant.
- Assert Reset during the 2nd ACCESS cycle of a write → OE=WE=1, gnt=00, ADDR=0 immediately; no done pulse afterwards. A CPU read after reset release completes normally.
- ACCESS_CYCLES=1 and ACCESS_CYCLES=4 builds → strobe width equals 1 and 4 cycles respectively; done latency equals ACCESS_CYCLES+1 cycles.
